// File: rtl/ls139_pkg.sv
// Shared constants and the 2-to-4 active-low decode function for the LS139 dual decoder.
package ls139_pkg;

  localparam logic [3:0] DEC_IDLE = 4'b1111;

  // Active-low one-hot of {b,a}; all high when the section is disabled.
  function automatic logic [3:0] decode2to4_n(input logic g_n, input logic b, input logic a);
    logic [3:0] y;
    y = DEC_IDLE;
    if (!g_n) begin
      y[{b, a}] = 1'b0;
    end
    return y;
  endfunction

endpackage

// File: rtl/ls139_section.sv
// One enable-gated 2-to-4 decoder section with an optional output register (REG_OUT).
module ls139_section
  import ls139_pkg::*;
#(
  parameter bit REG_OUT = 1'b1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       g_n,
  input  logic       b,
  input  logic       a,
  output logic [3:0] y_n
);

  logic [3:0] dec_n;

  assign dec_n = decode2to4_n(g_n, b, a);

  generate
    if (REG_OUT) begin : g_reg
      logic [3:0] y_q;

      always_ff @(posedge clk) begin
        if (!rst_n) begin
          y_q <= DEC_IDLE;
        end else begin
          y_q <= dec_n;
        end
      end

      assign y_n = y_q;
    end else begin : g_comb
      // Unregistered path is still held deasserted for as long as reset is low.
      assign y_n = rst_n ? dec_n : DEC_IDLE;
    end
  endgenerate

endmodule

// File: rtl/ls139_dual_decoder.sv
// Dual independent 2-to-4 decoder (SN74LS139 equivalent) with registered outputs.
// Define LS139_ACTIVE_HIGH_MIRROR_EN to add active-high one-hot mirror vectors y1_vec/y2_vec.
module ls139_dual_decoder
  import ls139_pkg::*;
#(
  parameter bit REG_OUT = 1'b1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       g1_n,
  input  logic       a1,
  input  logic       b1,
  output logic       y1_0_n,
  output logic       y1_1_n,
  output logic       y1_2_n,
  output logic       y1_3_n,
  input  logic       g2_n,
  input  logic       a2,
  input  logic       b2,
  output logic       y2_0_n,
  output logic       y2_1_n,
  output logic       y2_2_n,
  output logic       y2_3_n
`ifdef LS139_ACTIVE_HIGH_MIRROR_EN
  ,
  output logic [3:0] y1_vec,
  output logic [3:0] y2_vec
`endif
);

  logic [3:0] sec1_n;
  logic [3:0] sec2_n;

  ls139_section #(.REG_OUT(REG_OUT)) u_sec1 (
    .clk   (clk),
    .rst_n (rst_n),
    .g_n   (g1_n),
    .b     (b1),
    .a     (a1),
    .y_n   (sec1_n)
  );

  ls139_section #(.REG_OUT(REG_OUT)) u_sec2 (
    .clk   (clk),
    .rst_n (rst_n),
    .g_n   (g2_n),
    .b     (b2),
    .a     (a2),
    .y_n   (sec2_n)
  );

  assign {y1_3_n, y1_2_n, y1_1_n, y1_0_n} = sec1_n;
  assign {y2_3_n, y2_2_n, y2_1_n, y2_0_n} = sec2_n;

`ifdef LS139_ACTIVE_HIGH_MIRROR_EN
  // Mirrors derive from the section outputs so timing and reset value track exactly.
  assign y1_vec = ~sec1_n;
  assign y2_vec = ~sec2_n;
`endif

endmodule

// File: tb/tb_ls139_dual_decoder.sv
// Directed self-checking bench for ls139_dual_decoder (REG_OUT=1), mirror outputs checked when
// LS139_ACTIVE_HIGH_MIRROR_EN is defined.
module tb_ls139_dual_decoder;

  logic clk;
  logic rst_n;
  logic g1_n, a1, b1, g2_n, a2, b2;
  logic y1_0_n, y1_1_n, y1_2_n, y1_3_n;
  logic y2_0_n, y2_1_n, y2_2_n, y2_3_n;
`ifdef LS139_ACTIVE_HIGH_MIRROR_EN
  logic [3:0] y1_vec, y2_vec;
`endif

  int errors = 0;
  int checks = 0;

  ls139_dual_decoder #(.REG_OUT(1'b1)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .g1_n   (g1_n),
    .a1     (a1),
    .b1     (b1),
    .y1_0_n (y1_0_n),
    .y1_1_n (y1_1_n),
    .y1_2_n (y1_2_n),
    .y1_3_n (y1_3_n),
    .g2_n   (g2_n),
    .a2     (a2),
    .b2     (b2),
    .y2_0_n (y2_0_n),
    .y2_1_n (y2_1_n),
    .y2_2_n (y2_2_n),
    .y2_3_n (y2_3_n)
`ifdef LS139_ACTIVE_HIGH_MIRROR_EN
    ,
    .y1_vec (y1_vec),
    .y2_vec (y2_vec)
`endif
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic checkOutput(input string tag, input logic [7:0] observed, input logic [7:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %b, expected %b", tag, observed, expected);
    end
  endtask

  // Expected value packs {Y3..Y0 of section 1, Y3..Y0 of section 2}.
  task automatic checkNow(input string tag, input logic [7:0] expected);
    checkOutput(tag, {y1_3_n, y1_2_n, y1_1_n, y1_0_n, y2_3_n, y2_2_n, y2_1_n, y2_0_n}, expected);
`ifdef LS139_ACTIVE_HIGH_MIRROR_EN
    checkOutput({tag, "_mirror"}, {y1_vec, y2_vec}, ~expected);
`endif
  endtask

  task automatic applyStimulus(input logic rst, input logic g1, input logic bb1, input logic aa1,
                               input logic g2, input logic bb2, input logic aa2);
    rst_n = rst;
    g1_n  = g1;
    b1    = bb1;
    a1    = aa1;
    g2_n  = g2;
    b2    = bb2;
    a2    = aa2;
  endtask

  task automatic stepCheck(input string tag, input logic [7:0] expected);
    @(posedge clk);
    #1;
    checkNow(tag, expected);
  endtask

  logic [1:0] sweep_ba  [4] = '{2'b00, 2'b01, 2'b10, 2'b11};
  logic [3:0] sweep_exp [4] = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};

  initial begin
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    stepCheck("reset_edge1", 8'hFF);
    stepCheck("reset_edge2", 8'hFF);

    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    checkNow("release_pre_edge", 8'hFF);
    stepCheck("release_y0", 8'hEE);

    for (int i = 1; i < 4; i++) begin
      applyStimulus(1'b1, 1'b0, sweep_ba[i][1], sweep_ba[i][0], 1'b0, sweep_ba[i][1], sweep_ba[i][0]);
      checkNow($sformatf("sweep_latency_%0d", i), {sweep_exp[i-1], sweep_exp[i-1]});
      stepCheck($sformatf("sweep_ba_%0d", i), {sweep_exp[i], sweep_exp[i]});
    end

    applyStimulus(1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1);
    stepCheck("disable_ba11", 8'hFF);
    applyStimulus(1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1);
    stepCheck("reenable_y3", 8'h77);

    applyStimulus(1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
    stepCheck("indep_s1_on", 8'hDF);
    applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    stepCheck("indep_s2_on", 8'hFD);

    applyStimulus(1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1);
    stepCheck("midrst_pre", 8'h77);
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1);
    stepCheck("midrst_assert", 8'hFF);
    applyStimulus(1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1);
    checkNow("midrst_hold", 8'hFF);
    stepCheck("midrst_resume", 8'h77);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
